// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and types for the PS/2 key decoder.
// Prefix bytes, frame FSM encoding, default paddle keys.
package ps2_key_decoder_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [7:0] DEF_P1_UP = 8'h1D;
  localparam logic [7:0] DEF_P1_DN = 8'h1B;
  localparam logic [7:0] DEF_P2_UP = 8'h75;
  localparam logic [7:0] DEF_P2_DN = 8'h72;

  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_TIMEOUT    = 100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

endpackage

// File: rtl/ps2_input_filter.sv
// PS/2 line conditioning: 2-flop sync, clock glitch filter
// and a one-cycle strobe on each filtered falling edge.
module ps2_input_filter
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clock,
  input  logic ps2_data,
  output logic data_sync,
  output logic strobe
);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] window;
  logic                  filt;
  logic                  all_low;
  logic                  all_high;

  // newest synchronized sample plus FILTER_LEN-1 older ones
  assign window   = {hist, clk_sync[1]};
  assign all_low  = ~|window;
  assign all_high = &window;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      hist     <= '1;
      filt     <= 1'b1;
      strobe   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock};
      dat_sync <= {dat_sync[0], ps2_data};
      hist     <= window[FILTER_LEN-2:0];
      strobe   <= filt & all_low;
      if (all_low)
        filt <= 1'b0;
      else if (all_high)
        filt <= 1'b1;
    end
  end

  assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame decoder: validates frames, strips
// E0/F0 prefixes, emits key events and paddle held flags.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int         FILTER_LEN     = DEF_FILTER_LEN,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter logic [7:0] KEY_P1_UP      = DEF_P1_UP,
  parameter logic [7:0] KEY_P1_DN      = DEF_P1_DN,
  parameter logic [7:0] KEY_P2_UP      = DEF_P2_UP,
  parameter logic [7:0] KEY_P2_DN      = DEF_P2_DN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       done,
  output logic [7:0] tasta,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err,
  output logic       p1_up,
  output logic       p1_dn,
  output logic       p2_up,
  output logic       p2_dn
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  frame_state_t state;
  frame_state_t state_nxt;

  logic          strobe;
  logic          sdata;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          brk;
  logic          ext;
  logic          timeout;
  logic          frame_ok;
  logic          frame_bad;

  ps2_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clock     (clock),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .data_sync (sdata),
    .strobe    (strobe)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (strobe) begin
      unique case (state)
        ST_IDLE:
          if (!sdata) state_nxt = ST_DATA;
        ST_DATA:
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY:
          state_nxt = ST_STOP;
        ST_STOP:
          state_nxt = ST_IDLE;
        default:
          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    timeout = (state != ST_IDLE) && !strobe &&
              (timer == TW'(TIMEOUT_CYCLES - 1));
    frame_ok = strobe && (state == ST_STOP) &&
               sdata && (^{shreg, par_bit});
    frame_bad = strobe && (state == ST_STOP) && !frame_ok;
    frame_err = frame_bad | timeout;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      timer   <= '0;
    end else begin
      if (strobe || timeout || state == ST_IDLE)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      // an aborted frame leaves nothing behind
      if (timeout) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (strobe) begin
        unique case (state)
          ST_IDLE:
            bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {sdata, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY:
            par_bit <= sdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk      <= 1'b0;
      ext      <= 1'b0;
      done     <= 1'b0;
      tasta    <= '0;
      is_break <= 1'b0;
      is_ext   <= 1'b0;
      p1_up    <= 1'b0;
      p1_dn    <= 1'b0;
      p2_up    <= 1'b0;
      p2_dn    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (frame_ok) begin
        unique case (1'b1)
          shreg == PREFIX_EXT:
            ext <= 1'b1;
          shreg == PREFIX_BRK:
            brk <= 1'b1;
          default: begin
            tasta    <= shreg;
            is_break <= brk;
            is_ext   <= ext;
            done     <= 1'b1;
            brk      <= 1'b0;
            ext      <= 1'b0;
            if (!ext && shreg == KEY_P1_UP) p1_up <= ~brk;
            if (!ext && shreg == KEY_P1_DN) p1_dn <= ~brk;
            if (ext && shreg == KEY_P2_UP)  p2_up <= ~brk;
            if (ext && shreg == KEY_P2_DN)  p2_dn <= ~brk;
          end
        endcase
      end
    end
  end

endmodule
